quadencoderz_filtered: RTL and testbench

- Next-generation quadrature encoder with index. Replaces the bare 3-FF sampler with per-input synchronisers and a programmable glitch filter.
- Adds illegal-transition detection, index position capture, a homing handshake and edge-period measurement for velocity estimation.
- Sits between the encoder input pins and the host register interface; one instance per encoder channel.

---
 rtl/quadencoder_pkg.sv | 15 +
 rtl/quadencoder_filter.sv | 52 +++++
 rtl/quadencoderz_filtered.sv | 166 ++++++++++++++++
 tb/tb_quadencoderz_filtered.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/quadencoder_pkg.sv
// Shared constants and types for the filtered quadrature encoder.
package quadencoder_pkg;

  localparam int unsigned QT_X4 = 0;
  localparam int unsigned QT_X2 = 1;
  localparam int unsigned QT_X1 = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UP      = 2'd1,
    DOWN    = 2'd2,
    ILLEGAL = 2'd3
  } step_e;

endpackage

// File: rtl/quadencoder_filter.sv
// Two-FF synchroniser followed by a run-length glitch filter for one encoder pin.
module quadencoder_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  generate
    if (FILTER_LEN == 0) begin : g_bypass
      assign dout = s2_q;
    end else begin : g_filt
      localparam int unsigned CW = $clog2(FILTER_LEN + 1);
      logic [CW-1:0] cnt_q;
      logic          out_q;

      // Any sample equal to the current output restarts the run.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
          out_q <= 1'b0;
        end else if (s2_q != out_q) begin
          if (cnt_q == CW'(FILTER_LEN - 1)) begin
            out_q <= s2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end

      assign dout = out_q;
    end
  endgenerate

endmodule

// File: rtl/quadencoderz_filtered.sv
// Quadrature decoder with index: filtered inputs, error flag, index capture, homing, period.
module quadencoderz_filtered
  import quadencoder_pkg::*;
#(
  parameter int unsigned BITS       = 32,
  parameter int unsigned QUAD_TYPE  = 0,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned PBITS      = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a,
  input  logic                   b,
  input  logic                   z,
  input  logic                   index_enable,
  output logic                   index_out,
  input  logic                   err_clear,
  output logic signed [BITS-1:0] position,
  output logic        [BITS-1:0] index_pos,
  output logic                   index_valid,
  output logic                   err,
  output logic       [PBITS-1:0] period,
  output logic                   dir,
  output logic                   stalled
);

  localparam int unsigned SHIFT = (QUAD_TYPE == QT_X1) ? 2 : (QUAD_TYPE == QT_X2) ? 1 : 0;

  logic fa, fb, fz;

  quadencoder_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (.clk(clk), .rst(rst), .din(a), .dout(fa));
  quadencoder_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (.clk(clk), .rst(rst), .din(b), .dout(fb));
  quadencoder_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_z (.clk(clk), .rst(rst), .din(z), .dout(fz));

  logic             primed_q, pa_q, pb_q, pz_q;
  logic [BITS-1:0]  count_q, count_d;
  logic [BITS-1:0]  index_pos_q, index_pos_d;
  logic             index_valid_q, index_valid_d;
  logic             index_out_q, index_out_d;
  logic             index_wait_q, index_wait_d;
  logic             err_q, err_d;
  logic [PBITS-1:0] pcnt_q, pcnt_d;
  logic [PBITS-1:0] period_q, period_d;
  logic             dir_q, dir_d;
  logic             stalled_q, stalled_d;

  step_e step;
  logic  z_rise, home, counted, pcnt_sat;

  // pa/pb/pz are unconditionally loaded, so the priming cycle just suppresses decode.
  always_comb begin
    step = IDLE;
    if (primed_q) begin
      if ((fa ^ pa_q) && (fb ^ pb_q)) begin
        step = ILLEGAL;
      end else if ((fa ^ pa_q) || (fb ^ pb_q)) begin
        step = (fa ^ pb_q) ? UP : DOWN;
      end
    end
  end

  assign z_rise   = primed_q & fz & ~pz_q;
  assign home     = index_out_q & z_rise;
  assign counted  = (step == UP) || (step == DOWN);
  assign pcnt_sat = (pcnt_q == '1);

  always_comb begin
    count_d       = count_q;
    err_d         = err_q;
    index_pos_d   = index_pos_q;
    index_valid_d = z_rise;
    index_out_d   = index_out_q;
    index_wait_d  = index_wait_q;
    pcnt_d        = pcnt_q;
    period_d      = period_q;
    dir_d         = dir_q;
    stalled_d     = stalled_q;

    case (step)
      UP:      count_d = count_q + BITS'(1);
      DOWN:    count_d = count_q - BITS'(1);
      default: ;
    endcase

    if (step == ILLEGAL) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end

    if (z_rise) begin
      index_pos_d = count_q;
    end

    // Homing reset takes priority over a step in the same cycle.
    if (home) begin
      count_d      = '0;
      index_out_d  = 1'b0;
      index_wait_d = 1'b1;
    end else if (index_out_q && !index_enable) begin
      index_out_d = 1'b0;
    end else if (index_enable && !index_out_q && !index_wait_q) begin
      index_out_d = 1'b1;
    end

    if (index_wait_q && !index_enable) begin
      index_wait_d = 1'b0;
    end

    if (counted) begin
      period_d  = pcnt_sat ? pcnt_q : pcnt_q + PBITS'(1);
      pcnt_d    = '0;
      dir_d     = (step == UP);
      stalled_d = 1'b0;
    end else if (pcnt_sat) begin
      period_d  = pcnt_q;
      stalled_d = 1'b1;
    end else begin
      pcnt_d = pcnt_q + PBITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      primed_q      <= 1'b0;
      pa_q          <= 1'b0;
      pb_q          <= 1'b0;
      pz_q          <= 1'b0;
      count_q       <= '0;
      index_pos_q   <= '0;
      index_valid_q <= 1'b0;
      index_out_q   <= 1'b0;
      index_wait_q  <= 1'b0;
      err_q         <= 1'b0;
      pcnt_q        <= '0;
      period_q      <= '0;
      dir_q         <= 1'b0;
      stalled_q     <= 1'b0;
    end else begin
      primed_q      <= 1'b1;
      pa_q          <= fa;
      pb_q          <= fb;
      pz_q          <= fz;
      count_q       <= count_d;
      index_pos_q   <= index_pos_d;
      index_valid_q <= index_valid_d;
      index_out_q   <= index_out_d;
      index_wait_q  <= index_wait_d;
      err_q         <= err_d;
      pcnt_q        <= pcnt_d;
      period_q      <= period_d;
      dir_q         <= dir_d;
      stalled_q     <= stalled_d;
    end
  end

  assign position    = $signed(count_q) >>> SHIFT;
  assign index_pos   = index_pos_q;
  assign index_valid = index_valid_q;
  assign index_out   = index_out_q;
  assign err         = err_q;
  assign period      = period_q;
  assign dir         = dir_q;
  assign stalled     = stalled_q;

endmodule

// File: tb/tb_quadencoderz_filtered.sv
// Scoreboard bench: x4 and x1 instances share the pins; model predicts count, index and flags.
module tb_quadencoderz_filtered;

  logic clk = 1'b0;
  logic rst, a, b, z, index_enable, err_clear;

  logic signed [31:0] pos0, pos2;
  logic [31:0] ipos0, ipos2;
  logic        ival0, ival2, err0, err2, dir0, dir2, stl0, stl2, iout0, iout2;
  logic [7:0]  per0, per2;

  quadencoderz_filtered #(.BITS(32), .QUAD_TYPE(0), .FILTER_LEN(4), .PBITS(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .z(z), .index_enable(index_enable),
    .index_out(iout0), .err_clear(err_clear), .position(pos0), .index_pos(ipos0),
    .index_valid(ival0), .err(err0), .period(per0), .dir(dir0), .stalled(stl0)
  );

  quadencoderz_filtered #(.BITS(32), .QUAD_TYPE(2), .FILTER_LEN(4), .PBITS(8)) dut_x1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .z(z), .index_enable(index_enable),
    .index_out(iout2), .err_clear(err_clear), .position(pos2), .index_pos(ipos2),
    .index_valid(ival2), .err(err2), .period(per2), .dir(dir2), .stalled(stl2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cnt;
    logic        dir;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] idx_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          idx_pulses = 0;
  int          g = 0;
  logic [31:0] mcnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] x1_of(input logic [31:0] c);
    int v;
    v = int'(c);
    return 32'(v >>> 2);
  endfunction

  // Index captures are scored as they come out of the DUT.
  always @(negedge clk) begin
    if (ival0) begin
      idx_pulses++;
      if (idx_q.size() == 0) check("idx_extra", 32'd1, 32'd0);
      else check("index_pos", ipos0, idx_q.pop_front());
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic move(input int dirn, input int hold);
    exp_t e;
    g = (g + dirn) & 3;
    a = (g == 1) || (g == 2);
    b = (g == 2) || (g == 3);
    mcnt = mcnt + 32'(dirn);
    sb_q.push_back('{cnt: mcnt, dir: (dirn > 0)});
    cycles(hold);
    e = sb_q.pop_front();
    check("pos_x4", pos0, e.cnt);
    check("pos_x1", pos2, x1_of(e.cnt));
    check("dir", {31'd0, dir0}, {31'd0, e.dir});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    mcnt = '0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; a = 0; b = 0; z = 0; index_enable = 0; err_clear = 0;
    cycles(3);
    check("rst_pos", pos0, 32'd0);
    check("rst_outs", {iout0, ival0, err0, dir0, stl0, per0}, '0);
    rst = 1'b0;

    // 10 forward cycles, 20 clocks per state
    for (int i = 0; i < 40; i++) move(1, 20);
    check("fwd_pos", pos0, 32'd40);
    check("fwd_period", {24'd0, per0}, 32'd20);
    check("fwd_dir", {31'd0, dir0}, 32'd1);
    check("fwd_err", {31'd0, err0}, 32'd0);

    do_reset();
    for (int i = 0; i < 40; i++) move(-1, 20);
    check("rev_x1", pos2, 32'hFFFF_FFF6);
    check("rev_dir", {31'd0, dir2}, 32'd0);

    // 3-clock glitch on A must be swallowed
    a = 1'b1;
    cycles(3);
    a = 1'b0;
    cycles(15);
    check("glitch_pos", pos0, mcnt);
    a = 1'b1; b = 1'b1; g = 2;
    cycles(10);
    check("illegal_err", {31'd0, err0}, 32'd1);
    check("illegal_pos", pos0, mcnt);
    err_clear = 1'b1;
    cycles(1);
    err_clear = 1'b0;
    check("err_clear", {31'd0, err0}, 32'd0);
    move(-1, 10);
    move(-1, 10);

    // homing
    do_reset();
    for (int i = 0; i < 1234; i++) move(1, 8);
    index_enable = 1'b1;
    check("arm_before", {31'd0, iout0}, 32'd0);
    cycles(1);
    check("arm_after", {31'd0, iout0}, 32'd1);
    idx_q.push_back(32'd1234);
    z = 1'b1;
    cycles(10);
    mcnt = '0;
    check("home_pos", pos0, mcnt);
    check("home_iout", {31'd0, iout0}, 32'd0);
    z = 1'b0;
    cycles(10);
    for (int i = 0; i < 3; i++) move(1, 8);
    idx_q.push_back(mcnt);
    z = 1'b1;
    cycles(10);
    check("rehome_pos", pos0, 32'd3);
    check("rehome_iout", {31'd0, iout0}, 32'd0);
    z = 1'b0;
    index_enable = 1'b0;
    cycles(10);
    check("idx_pulses", 32'(idx_pulses), 32'd2);
    check("idx_pending", 32'(idx_q.size()), 32'd0);

    // wrap through 2^BITS-1, then stall
    move(-1, 10);
    do_reset();
    move(-1, 10);
    check("wrap_min", pos0, 32'hFFFF_FFFF);
    move(1, 10);
    check("wrap_zero", pos0, 32'd0);
    check("stl_before", {31'd0, stl0}, 32'd0);
    cycles(300);
    check("stl_after", {31'd0, stl0}, 32'd1);
    check("stl_period", {24'd0, per0}, 32'd255);
    check("stl_period_x1", {24'd0, per2}, 32'd255);

    // reset while armed with A = B = 1
    move(1, 10);
    move(1, 10);
    index_enable = 1'b1;
    cycles(3);
    check("pre_rst_iout", {31'd0, iout0}, 32'd1);
    rst = 1'b1;
    index_enable = 1'b0;
    cycles(2);
    check("mid_rst_pos", pos0 | pos2, 32'd0);
    check("mid_rst_outs", {iout0, ival0, err0, dir0, stl0, per0, iout2, dir2, per2}, '0);
    check("mid_rst_ipos", ipos0 | ipos2, 32'd0);
    rst = 1'b0;
    mcnt = '0;
    cycles(1);
    check("prime_pos", pos0, 32'd0);
    check("prime_err", {31'd0, err0}, 32'd0);
    cycles(1);
    check("post_prime_pos", pos0, 32'd0);
    // filtered A and B then rise together from the primed 0/0 state
    cycles(10);
    check("settle_err", {31'd0, err0}, 32'd1);
    check("settle_pos", pos0, 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
